// File: rtl/led_blink_pkg.sv
// Shared types and helpers for the LED event blinker.
// Holds the per-channel state encoding and the phase counter width function.
package led_blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } blink_state_t;

  // Width wide enough to hold the larger of the two phase lengths.
  function automatic int clog2_max(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/led_blink_channel.sv
// One LED channel: turns an event pulse into BLINKS on/off cycles.
// Latency: lit/busy change one clk after the pulse is sampled.
// No backpressure: events during a sequence restart it, never queue.
module led_blink_channel
  import led_blink_pkg::*;
#(
  parameter int ON_CYCLES  = 12_500_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int BLINKS     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic event_pulse,
  output logic lit,
  output logic busy
);

  localparam int PW = clog2_max(ON_CYCLES, OFF_CYCLES);
  localparam int BW = $clog2(BLINKS + 1);

  localparam logic [PW-1:0] ON_LAST    = PW'(ON_CYCLES - 1);
  localparam logic [PW-1:0] OFF_LAST   = PW'(OFF_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINKS - 1);

  if (ON_CYCLES < 1 || OFF_CYCLES < 1 || BLINKS < 1) begin : g_bad_param
    $error("led_blink_channel: ON_CYCLES, OFF_CYCLES and BLINKS must be >= 1");
  end

  blink_state_t    state;
  logic [PW-1:0]   phase_cnt;
  logic [BW-1:0]   blink_cnt;

  // lit/busy are registered alongside the state so they reflect the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      blink_cnt <= '0;
      lit       <= 1'b0;
      busy      <= 1'b0;
    end else if (event_pulse) begin
      state     <= ON;
      phase_cnt <= '0;
      blink_cnt <= '0;
      lit       <= 1'b1;
      busy      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          lit  <= 1'b0;
          busy <= 1'b0;
        end
        ON: begin
          if (phase_cnt == ON_LAST) begin
            phase_cnt <= '0;
            lit       <= 1'b0;
            if (blink_cnt == BLINK_LAST) begin
              state     <= IDLE;
              blink_cnt <= '0;
              busy      <= 1'b0;
            end else begin
              state     <= OFF;
              blink_cnt <= blink_cnt + 1'b1;
              busy      <= 1'b1;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        OFF: begin
          if (phase_cnt == OFF_LAST) begin
            state     <= ON;
            phase_cnt <= '0;
            lit       <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          phase_cnt <= '0;
          blink_cnt <= '0;
          lit       <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_event_blinker.sv
// N independent event-to-LED blink channels with selectable LED polarity.
// Latency: led/busy respond one clk after an event pulse is sampled.
// No backpressure: event pulses are always accepted, retriggering a channel.
module led_event_blinker
  import led_blink_pkg::*;
#(
  parameter int N          = 4,
  parameter int ON_CYCLES  = 12_500_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int BLINKS     = 2,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] event_pulse,
  output logic [N-1:0] led,
  output logic [N-1:0] busy
);

  if (N < 1) begin : g_bad_n
    $error("led_event_blinker: N must be >= 1");
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic lit;

    led_blink_channel #(
      .ON_CYCLES (ON_CYCLES),
      .OFF_CYCLES(OFF_CYCLES),
      .BLINKS    (BLINKS)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .event_pulse(event_pulse[i]),
      .lit        (lit),
      .busy       (busy[i])
    );

    // lit is a flop output, so the constant inversion keeps led glitch-free.
    assign led[i] = lit ^ ACTIVE_LOW;
  end

endmodule

// File: tb/tb_led_event_blinker.sv
// Directed bench: main instance (ON=3, OFF=2, BLINKS=2, active-high) plus
// an active-low, single-blink instance sharing clock and reset.
module tb_led_event_blinker;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] ev;
  logic [N-1:0] ev2;
  logic [N-1:0] led;
  logic [N-1:0] busy;
  logic [N-1:0] led2;
  logic [N-1:0] busy2;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  led_event_blinker #(
    .N(N), .ON_CYCLES(3), .OFF_CYCLES(2), .BLINKS(2), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .event_pulse(ev), .led(led), .busy(busy)
  );

  led_event_blinker #(
    .N(N), .ON_CYCLES(3), .OFF_CYCLES(2), .BLINKS(1), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .rst_n(rst_n), .event_pulse(ev2), .led(led2), .busy(busy2)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    ev    = '0;
    ev2   = '0;
    #12;
    checks++;
    if (led !== 4'b0000 || busy !== 4'b0000) begin
      fails++;
      $display("FAIL reset_during led=%b busy=%b expected 0000/0000", led, busy);
    end
    checks++;
    if (led2 !== 4'b1111 || busy2 !== 4'b0000) begin
      fails++;
      $display("FAIL reset_during_al led=%b busy=%b expected 1111/0000", led2, busy2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      checks++;
      if (led !== 4'b0000 || busy !== 4'b0000 || led2 !== 4'b1111 || busy2 !== 4'b0000) begin
        fails++;
        $display("FAIL reset_idle cycle %0d led=%b busy=%b led_al=%b busy_al=%b", j, led, busy, led2, busy2);
      end
    end
  endtask

  // Sample j is the value seen after edge k+j-1, i.e. "at k+j".
  task automatic test_single();
    logic [23:0] exp_led;
    logic [23:0] exp_busy;
    exp_led  = 24'h0001CE;
    exp_busy = 24'h0001FE;
    @(negedge clk);
    ev[0] = 1'b1;
    for (int j = 1; j < 24; j++) begin
      @(negedge clk);
      ev[0] = 1'b0;
      checks++;
      if (led[0] !== exp_led[j]) begin
        fails++;
        $display("FAIL single_led0 k+%0d got %b expected %b", j, led[0], exp_led[j]);
      end
      checks++;
      if (busy[0] !== exp_busy[j]) begin
        fails++;
        $display("FAIL single_busy0 k+%0d got %b expected %b", j, busy[0], exp_busy[j]);
      end
      checks++;
      if (led[3:1] !== 3'b000 || busy[3:1] !== 3'b000) begin
        fails++;
        $display("FAIL single_others k+%0d led=%b busy=%b expected 000/000", j, led[3:1], busy[3:1]);
      end
    end
  endtask

  task automatic test_retrigger();
    logic [23:0] exp_led;
    logic [23:0] exp_busy;
    exp_led  = 24'h0039CE;
    exp_busy = 24'h003FFE;
    @(negedge clk);
    ev[1] = 1'b1;
    for (int j = 1; j < 24; j++) begin
      @(negedge clk);
      ev[1] = (j == 5);
      checks++;
      if (led[1] !== exp_led[j]) begin
        fails++;
        $display("FAIL retrig_led1 k+%0d got %b expected %b", j, led[1], exp_led[j]);
      end
      checks++;
      if (busy[1] !== exp_busy[j]) begin
        fails++;
        $display("FAIL retrig_busy1 k+%0d got %b expected %b", j, busy[1], exp_busy[j]);
      end
    end
  endtask

  task automatic test_held();
    logic [23:0] exp_led;
    logic [23:0] exp_busy;
    exp_led  = 24'h0073FE;
    exp_busy = 24'h007FFE;
    @(negedge clk);
    ev[2] = 1'b1;
    for (int j = 1; j < 24; j++) begin
      @(negedge clk);
      ev[2] = (j < 7);
      checks++;
      if (led[2] !== exp_led[j]) begin
        fails++;
        $display("FAIL held_led2 k+%0d got %b expected %b", j, led[2], exp_led[j]);
      end
      checks++;
      if (busy[2] !== exp_busy[j]) begin
        fails++;
        $display("FAIL held_busy2 k+%0d got %b expected %b", j, busy[2], exp_busy[j]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    ev[3] = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      ev[3] = 1'b0;
    end
    checks++;
    if (led[3] !== 1'b1 || busy[3] !== 1'b1) begin
      fails++;
      $display("FAIL arst_pre led3=%b busy3=%b expected 1/1", led[3], busy[3]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (led[3] !== 1'b0 || busy[3] !== 1'b0) begin
      fails++;
      $display("FAIL arst_immediate led3=%b busy3=%b expected 0/0", led[3], busy[3]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      checks++;
      if (led !== 4'b0000 || busy !== 4'b0000) begin
        fails++;
        $display("FAIL arst_after cycle %0d led=%b busy=%b expected 0000/0000", j, led, busy);
      end
    end
  endtask

  task automatic test_active_low();
    logic [23:0] exp_lit;
    exp_lit = 24'h00000E;
    @(negedge clk);
    ev2[0] = 1'b1;
    for (int j = 1; j < 12; j++) begin
      @(negedge clk);
      ev2[0] = 1'b0;
      checks++;
      if (led2[0] !== ~exp_lit[j]) begin
        fails++;
        $display("FAIL al_led0 k+%0d got %b expected %b", j, led2[0], ~exp_lit[j]);
      end
      checks++;
      if (busy2[0] !== exp_lit[j]) begin
        fails++;
        $display("FAIL al_busy0 k+%0d got %b expected %b", j, busy2[0], exp_lit[j]);
      end
      checks++;
      if (led2[3:1] !== 3'b111 || busy2[3:1] !== 3'b000) begin
        fails++;
        $display("FAIL al_others k+%0d led=%b busy=%b expected 111/000", j, led2[3:1], busy2[3:1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_retrigger();
    test_held();
    test_async_reset();
    test_active_low();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/led_event_blinker.md
Name: led_event_blinker

Overview:
- Output-side counterpart to the key conditioning path. Key conditioning turns noisy push-buttons into single-cycle event pulses; this block turns single-cycle event pulses into human-visible LED blink sequences.
- N independent channels. Each channel accepts a 1-cycle event pulse from internal logic, such as a debounced key pulse, a frame-done strobe or an error strobe.
- On each event, the channel drives its LED through BLINKS on/off cycles of visible duration.
- Sits between the control logic and the board LED pins.

Parameters:
- N, 4: number of channels (event inputs / LED outputs).
- ON_CYCLES, 12_500_000: clk cycles per LED-on phase (100 ms at 125 MHz); must be >= 1.
- OFF_CYCLES, 12_500_000: clk cycles per LED-off gap between blinks; must be >= 1.
- BLINKS, 2: number of on-phases per event; must be >= 1.
- ACTIVE_LOW, 0: 1 inverts the led output polarity for active-low LED pins.

Ports:
- clk, input, 1: system clock; the block has one clock.
- rst_n, input, 1: asynchronous active-low reset.
- event_pulse, input, N: per-channel event strobe. Synchronous to clk; each cycle high is one event.
- led, output, N: per-channel LED drive, registered. Polarity is set by ACTIVE_LOW.
- busy, output, N: per-channel sequence-in-progress flag, registered.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: all channels go to IDLE, counters are cleared, busy = 0, led = {N{ACTIVE_LOW}} (LEDs dark).
- Deassertion of rst_n is assumed synchronised upstream.
- Channels are fully independent; no arbitration or shared state.
- Per-channel FSM, with states IDLE, ON and OFF:
  - IDLE: lit = 0, busy = 0. event_pulse -> ON, phase_cnt = 0, blink_cnt = 0.
  - ON: lit = 1, busy = 1. phase_cnt counts 0..ON_CYCLES-1. At terminal count:
    - if blink_cnt == BLINKS-1, go to IDLE (no trailing OFF gap);
    - otherwise go to OFF with phase_cnt = 0 and blink_cnt + 1.
  - OFF: lit = 0, busy = 1. phase_cnt counts 0..OFF_CYCLES-1. At terminal count, go to ON with phase_cnt = 0.
- led = lit XOR ACTIVE_LOW; busy = (state != IDLE). Both are registered outputs derived from the next state.
- Latency: a pulse sampled high at edge k gives led lit and busy = 1 from edge k+1.
- Sequence timing: BLINKS*ON_CYCLES + (BLINKS-1)*OFF_CYCLES cycles of busy, then busy = 0 on the following edge.
- Retrigger: event_pulse in ON or OFF restarts the sequence. Next state is ON with phase_cnt = 0 and blink_cnt = 0.
  - An LED already lit stays lit with no glitch.
  - Events are not queued or counted.
- Simultaneous event and terminal count: the retrigger has priority over the terminal-count transition.
- Event held high for several cycles: each cycle retriggers, so the LED stays lit until 1 cycle after release, then the full sequence runs.
- Counter widths: phase_cnt is $clog2(max(ON_CYCLES, OFF_CYCLES)+1) bits; blink_cnt is $clog2(BLINKS+1) bits. Neither counter wraps past its terminal value.
- Reset mid-sequence: asynchronous return to reset values on the same edge as rst_n falls.
- Elaboration error when ON_CYCLES, OFF_CYCLES or BLINKS is < 1, or N < 1.

Decomposition:
- Shared package led_blink_pkg:
  - state typedef blink_state_t (IDLE = 2'd0, ON = 2'd1, OFF = 2'd2);
  - function clog2_max for the counter width.
- One sub-module, led_blink_channel: a single-channel FSM plus counters with the same parameters except N.
- Top level led_event_blinker generates N instances and applies the ACTIVE_LOW inversion.

Test Plan (ON_CYCLES=3, OFF_CYCLES=2, BLINKS=2, N=4, ACTIVE_LOW=0 unless stated):
- Reset: rst_n low, then release -> led = 4'b0000, busy = 4'b0000, stable with no events for 50 cycles.
- Single event on ch0 at edge k:
  - led[0] = 1 at k+1..k+3, 0 at k+4..k+5, 1 at k+6..k+8, 0 from k+9;
  - busy[0] = 1 at k+1..k+8, 0 from k+9;
  - other channels untouched.
- Retrigger: event on ch1 at k, then again at k+5 (in OFF) -> led[1] = 1 at k+6..k+8, 0 at k+9..k+10, 1 at k+11..k+13, busy[1] falls at k+14.
- Held event: event_pulse[2] high for k..k+6 -> led[2] continuously 1 from k+1 through k+9, then 0 for 2 cycles, then 1 for 3 cycles, then idle.
- Async reset mid-sequence: rst_n falls during the second ON phase of ch3, between clock edges -> led[3] = 0 and busy[3] = 0 immediately. After release, ch3 stays idle until a new event.
- ACTIVE_LOW=1 with BLINKS=1: event on ch0 at k -> led[0] = 0 at k+1..k+3, 1 otherwise (including during and after reset); busy is unaffected by polarity.
